// File: rtl/mips_rf_pkg.sv
// Shared constants and helpers for the multi-port MIPS register file.
package mips_rf_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int REG_ZERO  = 0;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, any write clears, set wins on collision.
module regfile_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy
);

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W-1:0] ra;
  logic              hit;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (we[k]) busy_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    // Applied after the clears so a new producer supersedes a retiring one.
    if (issue_en && (issue_addr != ADDR_W'(REG_ZERO))) busy_d[issue_addr] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rbusy = '0;
    ra    = '0;
    hit   = 1'b0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra  = raddr[p*ADDR_W +: ADDR_W];
      hit = 1'b0;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == ra)) hit = 1'b1;
      end
      rbusy[p] = busy_q[ra] & ~((BYPASS != 0) & hit);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*WIDTH-1:0]  rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*WIDTH-1:0]  wdata,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr
);

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] ra;
  logic [WIDTH-1:0]  rd;

  // Ascending port order makes the highest-index port win a collision.
  always_comb begin
    regs_d = regs_q;
    wa     = '0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      wa = waddr[k*ADDR_W +: ADDR_W];
      if (we[k] && (wa != ADDR_W'(REG_ZERO))) regs_d[wa] = wdata[k*WIDTH +: WIDTH];
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata = '0;
    ra    = '0;
    rd    = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra = raddr[p*ADDR_W +: ADDR_W];
      rd = regs_q[ra];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == ra)) rd = wdata[k*WIDTH +: WIDTH];
        end
      end
      if (ra == ADDR_W'(REG_ZERO)) rd = '0;
      rdata[p*WIDTH +: WIDTH] = rd;
    end
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .we         (we),
    .waddr      (waddr),
    .raddr      (raddr),
    .rbusy      (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances driven in lockstep.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  raddr;
  logic [NR*W-1:0]   rdata_a, rdata_b;
  logic [NR-1:0]     rbusy_a, rbusy_b;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  waddr;
  logic [NW*W-1:0]   wdata;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_regs [D];
  logic [D-1:0] m_busy;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .we(we), .waddr(waddr), .wdata(wdata), .issue_en(issue_en), .issue_addr(issue_addr)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .we(we), .waddr(waddr), .wdata(wdata), .issue_en(issue_en), .issue_addr(issue_addr)
  );

  // Reference model of the architectural state.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      for (int k = 0; k < NW; k++)
        if (we[k] && waddr[k*AW +: AW] != 0) m_regs[waddr[k*AW +: AW]] = wdata[k*W +: W];
      for (int k = 0; k < NW; k++)
        if (we[k]) m_busy[waddr[k*AW +: AW]] = 1'b0;
      if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [3:0] a0, input logic [31:0] d0,
                       input logic [3:0] a1, input logic [31:0] d1, input logic ie,
                       input logic [3:0] ia, input logic [3:0] r0, input logic [3:0] r1,
                       input logic [3:0] r2);
    we = w;
    waddr = {a1, a0};
    wdata = {d1, d0};
    issue_en = ie;
    issue_addr = ia;
    raddr = {r2, r1, r0};
  endtask

  task automatic idle();
    drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < D; a++) begin
      raddr = {NR{4'(a)}};
      #1;
      chk($sformatf("%s rdata_a r%0d", tag, a), rdata_a[W-1:0], 32'd0);
      chk($sformatf("%s rdata_b r%0d", tag, a), rdata_b[2*W-1:W], 32'd0);
      chk($sformatf("%s rbusy_a r%0d", tag, a), {29'd0, rbusy_a}, 32'd0);
      chk($sformatf("%s rbusy_b r%0d", tag, a), {29'd0, rbusy_b}, 32'd0);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [3:0] ra, input bit byp);
    logic [W-1:0] v;
    if (ra == 0) return '0;
    v = m_regs[ra];
    if (byp) begin
      if (we[1] && waddr[7:4] == ra) v = wdata[63:32];
      else if (we[0] && waddr[3:0] == ra) v = wdata[31:0];
    end
    return v;
  endfunction

  function automatic logic exp_busy(input logic [3:0] ra, input bit byp);
    logic hit;
    hit = (we[1] && waddr[7:4] == ra) || (we[0] && waddr[3:0] == ra);
    return m_busy[ra] & ~(byp & hit);
  endfunction

  typedef struct {
    logic [1:0]  we;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [3:0]  ia;
    logic [3:0]  ra0;
    logic [3:0]  ra1;
    logic [31:0] ea0;
    logic [31:0] ea1;
    logic [31:0] eb0;
    logic        ba;
    logic        bb;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{2'b01, 4'd7, 32'h12345678, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd7, 32'h12345678, 32'h12345678, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 4'd0, 32'hFFFFFFFF, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd0, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 4'd3, 32'hA5A5A5A5, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd0, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd7, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 4'd9, 32'h1, 4'd9, 32'h2, 1'b0, 4'd0, 4'd9, 4'd9, 32'h2, 32'h2, 32'h0, 1'b0, 1'b0};
    tbl[5]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd3, 32'h2, 32'hA5A5A5A5, 32'h2, 1'b0, 1'b0};
    tbl[6]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd4, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1};
    tbl[8]  = '{2'b10, 4'd0, 32'h0, 4'd4, 32'h44, 1'b0, 4'd0, 4'd4, 4'd4, 32'h44, 32'h44, 32'h0, 1'b0, 1'b1};
    tbl[9]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd4, 32'h44, 32'h44, 32'h44, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 4'd4, 32'h55, 4'd0, 32'h0, 1'b1, 4'd4, 4'd4, 4'd0, 32'h55, 32'h0, 32'h44, 1'b0, 1'b0};
    tbl[11] = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd4, 4'd4, 32'h55, 32'h55, 32'h55, 1'b1, 1'b1};
    tbl[12] = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[13] = '{2'b10, 4'd0, 32'h0, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1, tbl[i].ie,
            tbl[i].ia, tbl[i].ra0, tbl[i].ra1, tbl[i].ra1);
      @(negedge clk);
      chk($sformatf("v%0d rdata_a p0", i), rdata_a[W-1:0], tbl[i].ea0);
      chk($sformatf("v%0d rdata_a p1", i), rdata_a[2*W-1:W], tbl[i].ea1);
      chk($sformatf("v%0d rdata_a p2", i), rdata_a[3*W-1:2*W], tbl[i].ea1);
      chk($sformatf("v%0d rdata_b p0", i), rdata_b[W-1:0], tbl[i].eb0);
      chk($sformatf("v%0d rbusy_a p0", i), {31'd0, rbusy_a[0]}, {31'd0, tbl[i].ba});
      chk($sformatf("v%0d rbusy_b p0", i), {31'd0, rbusy_b[0]}, {31'd0, tbl[i].bb});
      @(posedge clk);
      #1;
    end

    // Reset must override a write and an issue presented in the same cycle.
    rst = 1'b1;
    drive(2'b01, 4'd5, 32'h0000DEAD, 4'd0, 32'h0, 1'b1, 4'd6, 4'd0, 4'd0, 4'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    @(negedge clk);
    check_all_zero("reset_override");

    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(63) == 0);
      drive(2'($urandom), 4'($urandom), $urandom, 4'($urandom), $urandom,
            1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      @(negedge clk);
      if (!rst) begin
        for (int p = 0; p < NR; p++) begin
          chk($sformatf("rnd c%0d p%0d rdata_a", c, p), rdata_a[p*W +: W], exp_rd(raddr[p*AW +: AW], 1'b1));
          chk($sformatf("rnd c%0d p%0d rdata_b", c, p), rdata_b[p*W +: W], exp_rd(raddr[p*AW +: AW], 1'b0));
          chk($sformatf("rnd c%0d p%0d rbusy_a", c, p), {31'd0, rbusy_a[p]}, {31'd0, exp_busy(raddr[p*AW +: AW], 1'b1)});
          chk($sformatf("rnd c%0d p%0d rbusy_b", c, p), {31'd0, rbusy_b[p]}, {31'd0, exp_busy(raddr[p*AW +: AW], 1'b0)});
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
